// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline-stage definitions: buffer state encoding and helpers used by
// every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_stage_buf_pkg;

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   typedef enum logic [1:0] {
      ST_EMPTY = EMPTY,
      ST_ONE   = ONE,
      ST_FULL  = FULL
   } buf_state_e;

   // Number of buffered entries held in a given state.
   function automatic logic [1:0] occupancy_of(input buf_state_e s);
      case (s)
         ST_EMPTY: return 2'd0;
         ST_ONE:   return 2'd1;
         ST_FULL:  return 2'd2;
         default:  return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Two-entry valid/ready pipeline register (main + skid). in_ready depends only
// on registered state, so backpressure never forms a combinational path upstream.
module pipe_stage_buf
   import pipe_stage_buf_pkg::*;
#(
   parameter int unsigned      WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   buf_state_e       state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_fire, out_fire;

   assign in_ready  = (state_q != ST_FULL);
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q;
   assign occupancy = occupancy_of(state_q);

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               main_d  = in_data;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_fire && out_fire) begin
               main_d = in_data;
            end else if (in_fire) begin
               skid_d  = in_data;
               state_d = ST_FULL;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_fire) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // Flush discards the buffer; stale data in main/skid is harmless once empty.
      if (flush) begin
         state_d = ST_EMPTY;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         main_q  <= RESET_DATA;
         skid_q  <= RESET_DATA;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a queue model predicts accepted payloads,
// a negedge monitor compares DUT outputs against the queue head.
module tb_pipe_stage_buf;
   import pipe_stage_buf_pkg::*;

   localparam int             W       = 32;
   localparam logic [W-1:0]   RST_VAL = 32'hA5A5_0F0F;

   logic         clk = 1'b0;
   logic         reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] in_data, out_data;
   logic [1:0]   occupancy;

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [W-1:0] sb[$];
   bit           chk_en = 1'b0;
   int           pops = 0;
   bit           acc_last = 1'b0;
   bit           stall_prev = 1'b0;
   logic [W-1:0] prev_data = '0;

   always #5 clk = ~clk;

   pipe_stage_buf #(.WIDTH(W), .RESET_DATA(RST_VAL)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: updates the expected queue from the inputs seen at each edge.
   always @(posedge clk) begin
      bit inf, outf;
      acc_last = 1'b0;
      if (reset) begin
         sb.delete();
         chk_en = 1'b1;
      end else if (flush) begin
         sb.delete();
      end else begin
         inf  = in_valid && (sb.size() < 2);
         outf = out_ready && (sb.size() > 0);
         if (outf) void'(sb.pop_front());
         if (inf) begin
            sb.push_back(in_data);
            acc_last = 1'b1;
         end
      end
   end

   // Monitor: compares DUT outputs against the scoreboard between edges.
   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", out_valid, sb.size() > 0);
         check("in_ready", in_ready, sb.size() < 2);
         check("occupancy", occupancy, sb.size());
         if (sb.size() > 0 && out_valid) check("out_data", out_data, sb[0]);
         if (stall_prev) begin
            check("stall_data_stable", out_data, prev_data);
            check("stall_valid_stable", out_valid, 1'b1);
         end
         if (out_valid && out_ready && !reset && !flush) pops++;
         stall_prev = out_valid && !out_ready && !reset && !flush;
         prev_data  = out_data;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      int sent;
      int pops0;

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      cyc(); cyc();
      check("reset_out_data", out_data, RST_VAL);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_occupancy", occupancy, 2'd0);

      // Single payload with one-cycle latency.
      reset = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF;
      cyc();
      in_valid = 1'b0;
      check("lat_valid", out_valid, 1'b1);
      check("lat_data", out_data, 32'hDEADBEEF);
      cyc();
      check("lat_drain", out_valid, 1'b0);

      // Fill to FULL; third push must be ignored.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11; cyc();
      in_data = 32'h22; cyc();
      check("full_occ", occupancy, 2'd2);
      check("full_in_ready", in_ready, 1'b0);
      in_data = 32'h33; cyc();
      check("full_hold_occ", occupancy, 2'd2);
      check("full_hold_head", out_data, 32'h11);
      in_valid = 1'b0; out_ready = 1'b1; cyc();
      check("pop_second", out_data, 32'h22);
      cyc();
      check("pop_empty", out_valid, 1'b0);

      // Streaming at one payload per cycle.
      pops0 = pops;
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1; in_data = W'(i);
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      check("stream_count", pops - pops0, 100);

      // Flush in FULL drops the concurrent payload.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55; cyc();
      in_data = 32'h66; cyc();
      check("pre_flush_occ", occupancy, 2'd2);
      flush = 1'b1; in_data = 32'h44; cyc();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_occ", occupancy, 2'd0);
      check("flush_valid", out_valid, 1'b0);
      check("flush_in_ready", in_ready, 1'b1);
      out_ready = 1'b1; cyc(); cyc();

      // Reset beats flush and transfers in FULL.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77; cyc();
      in_data = 32'h88; cyc();
      in_valid = 1'b0;
      reset = 1'b1; flush = 1'b1; out_ready = 1'b1; cyc();
      reset = 1'b0; flush = 1'b0;
      check("rst_full_data", out_data, RST_VAL);
      check("rst_full_valid", out_valid, 1'b0);
      check("rst_full_in_ready", in_ready, 1'b1);

      // Random backpressure over 10k payloads.
      pops0 = pops;
      sent  = 0;
      while (sent < 10000) begin
         out_ready = 1'($urandom_range(0, 1));
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         cyc();
         if (acc_last) sent++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      cyc(); cyc(); cyc();
      check("random_count", pops - pops0, 10000);
      check("random_drained", out_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
